// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I op classes, opcodes, formats and immediate ranges
// Shared between the instruction encoder and the core decoder.
package riscv_pkg;

    typedef enum logic [3:0] {
        OP_LUI     = 4'd0,
        OP_AUIPC   = 4'd1,
        OP_JAL     = 4'd2,
        OP_JALR    = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_LOAD    = 4'd5,
        OP_STORE   = 4'd6,
        OP_ALU_IMM = 4'd7,
        OP_ALU_REG = 4'd8,
        OP_SYSTEM  = 4'd9
    } op_class_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPC_ALU_REG = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;
    localparam int SHAMT_MAX = 31;

    function automatic logic op_is_valid(input logic [3:0] op);
        return op <= OP_SYSTEM;
    endfunction

    function automatic fmt_e op_format(input logic [3:0] op);
        case (op)
            OP_LUI, OP_AUIPC:                         return FMT_U;
            OP_JAL:                                   return FMT_J;
            OP_BRANCH:                                return FMT_B;
            OP_STORE:                                 return FMT_S;
            OP_JALR, OP_LOAD, OP_ALU_IMM, OP_SYSTEM:  return FMT_I;
            default:                                  return FMT_R;
        endcase
    endfunction

    function automatic logic [6:0] op_opcode(input logic [3:0] op);
        case (op)
            OP_LUI:     return OPC_LUI;
            OP_AUIPC:   return OPC_AUIPC;
            OP_JAL:     return OPC_JAL;
            OP_JALR:    return OPC_JALR;
            OP_BRANCH:  return OPC_BRANCH;
            OP_LOAD:    return OPC_LOAD;
            OP_STORE:   return OPC_STORE;
            OP_ALU_IMM: return OPC_ALU_IMM;
            OP_ALU_REG: return OPC_ALU_REG;
            OP_SYSTEM:  return OPC_SYSTEM;
            default:    return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
// Ports: clk, resetn (async active-low), push/push_data, pop/pop_data (head,
// valid when count != 0), count (0..DEPTH). DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Overflow/underflow requests are ignored so the caller cannot corrupt state.
    assign w_do_push = push && (r_count != FULL_CNT);
    assign w_do_pop  = pop && (r_count != '0);
    assign pop_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming RV32I instruction encoder with address tagging
// Ports: clk, resetn (async active-low); request side in_valid/in_ready with
// in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm; output side
// out_valid/out_ready with out_instr, out_addr; error side err_sticky,
// err_count (saturating) and clr_err.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter int          ADDR_W     = 16,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_sticky,
    input  logic              clr_err,
    output logic [7:0]        err_count
);

    localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_RST = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(4);

    logic [ADDR_W-1:0]       r_addr;
    logic                    r_err_sticky;
    logic [7:0]              r_err_count;

    fmt_e                    w_fmt;
    logic [6:0]              w_opcode;
    logic [2:0]              w_funct3;
    logic                    w_is_shift;
    logic signed [31:0]      w_imm_s;
    logic                    w_legal;
    logic [31:0]             w_instr;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic [CNT_W-1:0]        w_count;
    logic [32+ADDR_W-1:0]    w_head;

    assign w_imm_s  = in_imm;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = out_valid && out_ready;

    // Ready is derived only from the registered count, so a full FIFO stays
    // closed for one cycle even when the head is being drained.
    assign in_ready  = (w_count != FULL_CNT);
    assign out_valid = (w_count != '0);
    assign out_instr = w_head[32+ADDR_W-1:ADDR_W];
    assign out_addr  = w_head[ADDR_W-1:0];

    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

    always_comb begin
        w_fmt      = op_format(in_op);
        w_opcode   = op_opcode(in_op);
        w_funct3   = (in_op == OP_JALR) ? 3'b000 : in_funct3;
        // SLLI/SRLI/SRAI carry a 5-bit shamt with funct7 in the upper bits.
        w_is_shift = (in_op == OP_ALU_IMM) && (in_funct3[1:0] == 2'b01);
        w_legal    = 1'b1;
        w_instr    = '0;
        case (w_fmt)
            FMT_R: begin
                w_instr = {in_funct7, in_rs2, in_rs1, w_funct3, in_rd, w_opcode};
            end
            FMT_I: begin
                if (w_is_shift) begin
                    w_legal = (w_imm_s >= 0) && (w_imm_s <= SHAMT_MAX);
                    w_instr = {in_funct7, in_imm[4:0], in_rs1, w_funct3, in_rd, w_opcode};
                end else begin
                    w_legal = (w_imm_s >= IMM_I_MIN) && (w_imm_s <= IMM_I_MAX);
                    w_instr = {in_imm[11:0], in_rs1, w_funct3, in_rd, w_opcode};
                end
            end
            FMT_S: begin
                w_legal = (w_imm_s >= IMM_I_MIN) && (w_imm_s <= IMM_I_MAX);
                w_instr = {in_imm[11:5], in_rs2, in_rs1, w_funct3, in_imm[4:0], w_opcode};
            end
            FMT_B: begin
                w_legal = (w_imm_s >= IMM_B_MIN) && (w_imm_s <= IMM_B_MAX) && !in_imm[0];
                w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_funct3,
                           in_imm[4:1], in_imm[11], w_opcode};
            end
            FMT_U: begin
                w_legal = (in_imm[11:0] == 12'd0);
                w_instr = {in_imm[31:12], in_rd, w_opcode};
            end
            FMT_J: begin
                w_legal = (w_imm_s >= IMM_J_MIN) && (w_imm_s <= IMM_J_MAX) && !in_imm[0];
                w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_opcode};
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        if (!op_is_valid(in_op)) begin
            w_legal = 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (32 + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_push),
        .push_data ({w_instr, r_addr}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (w_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr <= ADDR_RST;
        end else if (w_push) begin
            r_addr <= r_addr + ADDR_INC;
        end
    end

    // A clear in the same cycle as a dropped request wins; that drop is not counted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= 8'd0;
        end else if (clr_err) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= 8'd0;
        end else if (w_accept && !w_legal) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        resetn, in_valid, in_ready, out_valid, out_ready, err_sticky, clr_err;
    logic [3:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm, out_instr;
    logic [15:0] out_addr;
    logic [7:0]  err_count;

    logic        b_resetn, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err_sticky;
    logic [31:0] b_out_instr;
    logic [3:0]  b_out_addr;
    logic [7:0]  b_err_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_encoder #(.FIFO_DEPTH(2), .ADDR_W(16), .BASE_ADDR(0)) u_dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_sticky(err_sticky), .clr_err(clr_err),
        .err_count(err_count)
    );

    instr_encoder #(.FIFO_DEPTH(2), .ADDR_W(4), .BASE_ADDR(0)) u_small (
        .clk(clk), .resetn(b_resetn), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_op(4'd7), .in_rd(5'd1), .in_rs1(5'd0), .in_rs2(5'd0),
        .in_funct3(3'd0), .in_funct7(7'd0), .in_imm(32'd5),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
        .out_addr(b_out_addr), .err_sticky(b_err_sticky), .clr_err(1'b0),
        .err_count(b_err_count)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          legal;
        logic [31:0] instr;
    } vec_t;

    vec_t vt[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input vec_t v);
        in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
    endtask

    function automatic logic [31:0] fld(input logic [31:0] x, input int hi, input int lo);
        return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    // Reference encoder built from the instruction-set field tables.
    function automatic void ref_encode(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] imm,
                                       output bit legal, output logic [31:0] w);
        int s;
        logic [31:0] regs;
        s = $signed(imm);
        regs = (32'(rs1) << 15) | (32'(f3) << 12);
        legal = 1'b1;
        w = 32'd0;
        case (op)
            4'd0, 4'd1: begin
                legal = (imm % 4096) == 0;
                w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | ((op == 4'd0) ? 32'h37 : 32'h17);
            end
            4'd2: begin
                legal = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
                w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
                  | (fld(imm, 19, 12) << 12) | (32'(rd) << 7) | 32'h6F;
            end
            4'd4: begin
                legal = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
                w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (32'(rs2) << 20) | regs
                  | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 32'h63;
            end
            4'd6: begin
                legal = (s >= -2048) && (s <= 2047);
                w = (fld(imm, 11, 5) << 25) | (32'(rs2) << 20) | regs | (fld(imm, 4, 0) << 7) | 32'h23;
            end
            4'd8: begin
                w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'h33;
            end
            4'd7: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    legal = (s >= 0) && (s <= 31);
                    w = (32'(f7) << 25) | (fld(imm, 4, 0) << 20) | regs | (32'(rd) << 7) | 32'h13;
                end else begin
                    legal = (s >= -2048) && (s <= 2047);
                    w = (fld(imm, 11, 0) << 20) | regs | (32'(rd) << 7) | 32'h13;
                end
            end
            4'd3, 4'd5, 4'd9: begin
                legal = (s >= -2048) && (s <= 2047);
                if (op == 4'd3) regs = 32'(rs1) << 15;
                w = (fld(imm, 11, 0) << 20) | regs | (32'(rd) << 7)
                  | ((op == 4'd3) ? 32'h67 : (op == 4'd5) ? 32'h03 : 32'h73);
            end
            default: legal = 1'b0;
        endcase
    endfunction

    logic [47:0] q[$];
    logic [15:0] exp_addr;
    logic [15:0] m_addr;
    int          m_err;
    bit          m_sticky;

    initial begin
        vt[0]  = '{4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd5,        1'b1, 32'h00500093};
        vt[1]  = '{4'd8, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,    32'd0,        1'b1, 32'h002081B3};
        vt[2]  = '{4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFFFFFFC, 1'b1, 32'hFE000EE3};
        vt[3]  = '{4'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,    32'h12345000, 1'b1, 32'h123452B7};
        vt[4]  = '{4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd2048,     1'b1, 32'h001000EF};
        vt[5]  = '{4'd6, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0,    32'hFFFFFFFF, 1'b1, 32'hFE312FA3};
        vt[6]  = '{4'd3, 5'd1, 5'd5, 5'd0, 3'd7, 7'd0,    32'd2047,     1'b1, 32'h7FF280E7};
        vt[7]  = '{4'd7, 5'd2, 5'd2, 5'd0, 3'd5, 7'h20,   32'd31,       1'b1, 32'h41F15113};
        vt[8]  = '{4'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFFFF000, 1'b1, 32'hFFFFF017};
        vt[9]  = '{4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'd1,        1'b1, 32'h00100073};
        vt[10] = '{4'd5, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0,    32'hFFFFF800, 1'b1, 32'h80012203};
        vt[11] = '{4'd4, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0,    32'd4094,     1'b1, 32'h7E209FE3};
        vt[12] = '{4'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFF00000, 1'b1, 32'h8000006F};
        vt[13] = '{4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd2048,     1'b0, 32'h0};
        vt[14] = '{4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'd3,        1'b0, 32'h0};
        vt[15] = '{4'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd1,        1'b0, 32'h0};
        vt[16] = '{4'd10, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,   32'd0,        1'b0, 32'h0};
        vt[17] = '{4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'd4096,     1'b0, 32'h0};
        vt[18] = '{4'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'd1048576,  1'b0, 32'h0};
        vt[19] = '{4'd7, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0,    32'd32,       1'b0, 32'h0};
        vt[20] = '{4'd6, 5'd0, 5'd1, 5'd1, 3'd2, 7'd0,    32'hFFFFF7FF, 1'b0, 32'h0};
        vt[21] = '{4'd7, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0,    32'hFFFFFFFF, 1'b0, 32'h0};

        resetn = 1'b0; b_resetn = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        set_req(vt[0]);
        cyc(); cyc();
        resetn = 1'b1; b_resetn = 1'b1;
        cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);

        // Table: one request at a time, drained immediately.
        exp_addr = 16'h0000;
        for (int i = 0; i < 22; i++) begin
            set_req(vt[i]);
            in_valid = 1'b1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd1);
            cyc();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vt[i].legal));
            if (vt[i].legal) begin
                chk($sformatf("tbl%0d_instr", i), out_instr, vt[i].instr);
                chk($sformatf("tbl%0d_addr", i), 32'(out_addr), 32'(exp_addr));
                exp_addr = exp_addr + 16'd4;
                cyc();
                chk($sformatf("tbl%0d_drained", i), 32'(out_valid), 32'd0);
            end
        end
        chk("tbl_err_count", 32'(err_count), 32'd9);
        chk("tbl_err_sticky", 32'(err_sticky), 32'd1);

        // Legal word after the drops keeps the unchanged address.
        set_req(vt[0]); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("post_err_addr", 32'(out_addr), 32'(exp_addr));
        exp_addr = exp_addr + 16'd4;
        cyc();

        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        chk("clr_err_count", 32'(err_count), 32'd0);
        chk("clr_err_sticky", 32'(err_sticky), 32'd0);

        // Clear coincident with an error: clear wins, error not counted.
        set_req(vt[13]); in_valid = 1'b1; clr_err = 1'b1;
        cyc();
        in_valid = 1'b0; clr_err = 1'b0;
        chk("clr_vs_err_count", 32'(err_count), 32'd0);
        chk("clr_vs_err_sticky", 32'(err_sticky), 32'd0);

        // Backpressure: three back-to-back requests with out_ready low.
        out_ready = 1'b0;
        set_req(vt[0]); in_imm = 32'd1; in_valid = 1'b1;
        chk("bp_a_ready", 32'(in_ready), 32'd1);
        cyc();
        in_imm = 32'd2;
        chk("bp_b_ready", 32'(in_ready), 32'd1);
        chk("bp_a_head", out_instr, 32'h00100093);
        cyc();
        in_imm = 32'd3;
        for (int k = 0; k < 3; k++) begin
            chk("bp_full_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_instr", out_instr, 32'h00100093);
            chk("bp_hold_addr", 32'(out_addr), 32'(exp_addr));
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            cyc();
        end
        out_ready = 1'b1;
        chk("bp_pop_no_push", 32'(in_ready), 32'd0);
        cyc();
        chk("bp_b_instr", out_instr, 32'h00200093);
        chk("bp_b_addr", 32'(out_addr), 32'(exp_addr + 16'd4));
        chk("bp_c_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("bp_c_instr", out_instr, 32'h00300093);
        chk("bp_c_addr", 32'(out_addr), 32'(exp_addr + 16'd8));
        cyc();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Narrow address wrap on the ADDR_W=4 instance.
        for (int i = 0; i < 5; i++) begin
            b_in_valid = 1'b1;
            cyc();
            b_in_valid = 1'b0;
            chk($sformatf("wrap%0d_valid", i), 32'(b_out_valid), 32'd1);
            chk($sformatf("wrap%0d_addr", i), 32'(b_out_addr), 32'((i * 4) % 16));
            cyc();
        end
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        cyc(); cyc();
        b_in_valid = 1'b0;
        chk("mid_rst_queued", 32'(b_out_valid), 32'd1);
        #2 b_resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(b_out_valid), 32'd0);
        chk("mid_rst_ready", 32'(b_in_ready), 32'd1);
        cyc();
        b_resetn = 1'b1;
        cyc();
        chk("post_rst_no_output", 32'(b_out_valid), 32'd0);
        b_out_ready = 1'b1; b_in_valid = 1'b1;
        cyc();
        b_in_valid = 1'b0;
        chk("post_rst_addr", 32'(b_out_addr), 32'd0);
        chk("post_rst_instr", b_out_instr, 32'h00500093);
        cyc();

        // Randomized traffic against the reference model from a fresh reset.
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        q.delete();
        m_addr = 16'd0; m_err = 0; m_sticky = 1'b0;
        for (int n = 0; n < 600; n++) begin
            bit          acc, pop, legal;
            logic [31:0] w;
            int          mode;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 4'($urandom_range(0, 11));
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_funct3 = 3'($urandom);
            in_funct7 = 7'($urandom);
            mode      = $urandom_range(0, 3);
            case (mode)
                0:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1:       in_imm = $urandom;
                2:       in_imm = $urandom & 32'hFFFFF000;
                default: in_imm = 32'($urandom_range(0, 40));
            endcase
            out_ready = ($urandom_range(0, 2) != 0);
            clr_err   = ($urandom_range(0, 49) == 0);

            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
            pop = out_valid && out_ready && (q.size() != 0);
            if (pop) begin
                chk("rnd_instr", out_instr, q[0][47:16]);
                chk("rnd_addr", 32'(out_addr), 32'(q[0][15:0]));
            end
            acc = in_valid && in_ready;
            ref_encode(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, legal, w);
            cyc();
            if (pop) void'(q.pop_front());
            if (acc && legal) begin
                q.push_back({w, m_addr});
                m_addr = m_addr + 16'd4;
            end
            if (clr_err) begin
                m_err = 0; m_sticky = 1'b0;
            end else if (acc && !legal) begin
                m_sticky = 1'b1;
                if (m_err < 255) m_err++;
            end
            chk("rnd_err_count", 32'(err_count), 32'(m_err));
            chk("rnd_err_sticky", 32'(err_sticky), 32'(m_sticky));
        end
        in_valid = 1'b0; clr_err = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
